// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates the decode-stage branch condition, reports the
// outcome one cycle later, keeps branch statistics and trains a bimodal BHT.
module branch_resolve_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic              stall_d,
  input  logic [3:0]        branch_d,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [PC_W-1:0]   pc_d,
  input  logic              pred_taken_d,
  input  logic [PC_W-1:0]   pred_pc_f,
  output logic              pred_taken_f,
  output logic              res_valid_e,
  output logic              res_taken_e,
  output logic              res_mispredict_e,
  output logic [PC_W-1:0]   res_pc_e,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_EQ   = 4'd1,
    BR_NE   = 4'd2,
    BR_LTZ  = 4'd3,
    BR_LEZ  = 4'd4,
    BR_GTZ  = 4'd5,
    BR_GEZ  = 4'd6,
    BR_LT   = 4'd7,
    BR_GE   = 4'd8,
    BR_LTU  = 4'd9,
    BR_GEU  = 4'd10
  } br_code_e;

  logic             a_neg;
  logic             a_zero;
  logic             cond;
  logic             resolving;
  logic             mispredict;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] look_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       next_ctr;
  logic [1:0]       bht [BHT_DEPTH];
  logic             unused_pred_pc;

  assign a_neg  = src_a[DATA_W-1];
  assign a_zero = (src_a == '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cond = 1'b0;
    case (br_code_e'(branch_d))
      BR_EQ:   cond = (src_a == src_b);
      BR_NE:   cond = (src_a != src_b);
      BR_LTZ:  cond = a_neg;
      BR_LEZ:  cond = a_neg | a_zero;
      BR_GTZ:  cond = ~a_neg & ~a_zero;
      BR_GEZ:  cond = ~a_neg;
      BR_LT:   cond = ($signed(src_a) <  $signed(src_b));
      BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
      BR_LTU:  cond = (src_a <  src_b);
      BR_GEU:  cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign resolving  = valid_d & ~stall_d & (branch_d inside {[4'd1:4'd10]});
  assign mispredict = cond ^ pred_taken_d;

  // Word-aligned PCs: bits [1:0] never distinguish branches, so skip them.
  assign upd_idx  = pc_d[IDX_W+1:2];
  assign look_idx = pred_pc_f[IDX_W+1:2];

  // The table is read before the clock edge, so a same-cycle update is not
  // visible to the fetch lookup until the next cycle.
  assign pred_taken_f = bht[look_idx][1];

  assign unused_pred_pc = ^pred_pc_f;

  always_comb begin
    cur_ctr  = bht[upd_idx];
    next_ctr = cur_ctr;
    if (cond) begin
      if (cur_ctr != 2'b11) next_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) next_ctr = cur_ctr - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_e      <= 1'b0;
      res_taken_e      <= 1'b0;
      res_mispredict_e <= 1'b0;
      res_pc_e         <= '0;
      branch_cnt       <= '0;
      mispredict_cnt   <= '0;
      // NOTE: the table is reset entry by entry (weakly not-taken), which
      // keeps it in flops rather than RAM; predictions must be defined
      // immediately after reset.
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else begin
      res_valid_e      <= resolving;
      res_taken_e      <= resolving & cond;
      res_mispredict_e <= resolving & mispredict;
      if (resolving) begin
        res_pc_e     <= pc_d;
        bht[upd_idx] <= next_ctr;
        if (branch_cnt != '1) begin
          branch_cnt <= branch_cnt + CNT_W'(1);
        end
        if (mispredict && (mispredict_cnt != '1)) begin
          mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand width in bits.
REQ-002 Parameter PC_W, default 32: program-counter width in bits.
REQ-003 Parameter BHT_DEPTH, default 16: branch-history-table entries; power of 2, minimum 2.
REQ-004 Parameter CNT_W, default 32: statistics counter width in bits.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 valid_d  in  1  decode-stage branch slot holds a live instruction.
REQ-008 stall_d  in  1  decode stalled; the slot is neither resolved nor recorded.
REQ-009 branch_d  in  4  condition code, per REQ-014.
REQ-010 src_a / src_b  in  DATA_W each  forwarded operands.
REQ-011 pc_d / pred_taken_d  in  PC_W / 1  branch PC and the prediction made at fetch.
REQ-012 pred_pc_f  in  PC_W; pred_taken_f  out  1  fetch-stage prediction lookup.
REQ-013 res_valid_e, res_taken_e, res_mispredict_e  out  1 each; res_pc_e  out  PC_W; branch_cnt, mispredict_cnt  out  CNT_W each.

Function
REQ-014 Codes: 0 none; 1 A==B; 2 A!=B; 3 A<0; 4 A<=0; 5 A>0; 6 A>=0; 7 A<B signed; 8 A>=B signed; 9 A<B unsigned; 10 A>=B unsigned; 11-15 treated as none.
REQ-015 Signed tests use two's complement over DATA_W bits; A<=0 is sign bit OR all-zero; A>0 is NOT sign bit AND NOT all-zero.
REQ-016 A slot is resolving when valid_d=1, stall_d=0, and branch_d is in 1..10.
REQ-017 Latency is 1 cycle: res_* registers capture a resolving slot's result on the following edge.
REQ-018 res_valid_e is 1 for exactly one cycle per resolving slot, and 0 otherwise.
REQ-019 res_taken_e is the evaluated condition.
REQ-020 res_mispredict_e is res_taken_e XOR the captured pred_taken_d.
REQ-021 res_pc_e equals the captured pc_d.
REQ-022 When res_valid_e=0, res_taken_e and res_mispredict_e are 0 and res_pc_e holds its last value.
REQ-023 BHT entries are 2-bit saturating counters indexed by PC bits [log2(BHT_DEPTH)+1:2].
REQ-024 pred_taken_f is combinational and equals bit 1 of entry[index(pred_pc_f)].
REQ-025 On each resolving slot, entry[index(pc_d)] increments if taken, saturating at 3, and decrements if not taken, saturating at 0.
REQ-026 Lookup of the entry being updated in the same cycle returns the pre-update value.
REQ-027 branch_cnt increments by 1 per resolving slot.
REQ-028 mispredict_cnt increments by 1 per resolving slot whose outcome differs from pred_taken_d.
REQ-029 Both statistics counters saturate at 2^CNT_W-1 and do not wrap.
REQ-030 Non-resolving cycles change no BHT entry or counter; this includes stall, invalid slots, and codes 0 and 11-15.
REQ-031 Fetch-to-decode PC aliasing is permitted; there are no tags.

Reset
REQ-032 While rst=1 at an edge, res_valid_e, res_taken_e, res_mispredict_e, res_pc_e, branch_cnt, and mispredict_cnt load 0, and every BHT entry loads 2'b01.
REQ-033 rst takes priority over a resolving slot in the same cycle; that slot is dropped with no update.
REQ-034 After reset, pred_taken_f=0 for every PC.

Verification
REQ-035 BEQ: A=5, B=5, code 1, pred 0, pc=0x40 -> next cycle res_valid_e=1, taken=1, mispredict=1, res_pc_e=0x40; entry[0] goes 1->2; mispredict_cnt=1.
REQ-036 Signed vs unsigned: A=0xFFFFFFFF, B=1 -> code 7 taken=1; code 9 taken=0; code 4 taken=1; code 5 taken=0.
REQ-037 Saturation: four taken resolutions at pc=0x8 -> entry[2] reaches 3 and stays there; pred_taken_f(0x8)=1; then one not-taken resolution -> entry=2, prediction still 1.
REQ-038 Stall/idle: stall_d=1 with valid code, then valid_d=0, then code 12 -> res_valid_e stays 0; counters and BHT unchanged.
REQ-039 Same-cycle hazard: resolve taken at pc=0x4 from entry=1 while pred_pc_f=0x4 -> pred_taken_f=0 in that cycle and 1 in the next.
REQ-040 Reset mid-stream: rst=1 coincident with a resolving slot -> next cycle all outputs are 0, the slot is not counted, and all entries are 1.
